// File: rtl/complex_pkg.sv
// Shared types and constants for the complex-number controller: opcodes,
// instruction field positions, FSM states and the packed complex word.
package complex_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 16;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 14;
    localparam int BANK_BIT = 13;
    localparam int SRC1_HI  = 12;
    localparam int SRC1_LO  = 9;
    localparam int SRC2_HI  = 8;
    localparam int SRC2_LO  = 5;
    localparam int DEST_HI  = 4;
    localparam int DEST_LO  = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        READ2,
        EXEC,
        WRITE,
        HALTED
    } state_t;

    typedef struct packed {
        logic signed [7:0] re;
        logic signed [7:0] im;
    } cplx_t;

endpackage

// File: rtl/complex_controller_if.sv
// Single-port memory bus between the controller (master) and the shared
// memory (slave); the memory samples on the falling edge.
interface complex_controller_if
    import complex_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_readwriteN;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_address,
        output mem_readwriteN,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_address,
        input  mem_readwriteN,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/complex_alu.sv
// Combinational complex add/sub/mul; every result part wraps to 8 bits.
module complex_alu
    import complex_pkg::*;
(
    input  cplx_t      a,
    input  cplx_t      b,
    input  logic [1:0] op,
    output cplx_t      result
);
    logic signed [15:0] w_ar, w_ai, w_br, w_bi;
    logic signed [15:0] w_rr, w_ii, w_ri, w_ir;
    logic        [7:0]  w_mul_re, w_mul_im;

    assign w_ar = {{8{a.re[7]}}, a.re};
    assign w_ai = {{8{a.im[7]}}, a.im};
    assign w_br = {{8{b.re[7]}}, b.re};
    assign w_bi = {{8{b.im[7]}}, b.im};

    assign w_rr = w_ar * w_br;
    assign w_ii = w_ai * w_bi;
    assign w_ri = w_ar * w_bi;
    assign w_ir = w_ai * w_br;

    // Full 16-bit sum is formed first, then truncated.
    assign w_mul_re = 8'(w_rr - w_ii);
    assign w_mul_im = 8'(w_ri + w_ir);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: begin
                result.re = a.re + b.re;
                result.im = a.im + b.im;
            end
            OP_SUB: begin
                result.re = a.re - b.re;
                result.im = a.im - b.im;
            end
            OP_MUL: begin
                result.re = w_mul_re;
                result.im = w_mul_im;
            end
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/complex_controller.sv
// Sequencer that fetches, reads two operands, executes and writes back,
// acting as the sole initiator on the shared single-port memory.
//   state  | meaning
//   IDLE   | waiting for start, memory idle (read addr 0)
//   FETCH  | read instruction at pc, then pc+1
//   DECODE | halt check; otherwise read operand A at {bank,src1}
//   READ2  | read operand B at {bank,src2}
//   EXEC   | compute result, memory idle
//   WRITE  | write result to dest
//   HALTED | done high, waiting for start
module complex_controller
    import complex_pkg::*;
#(
    parameter int                ADDR_W     = MEM_ADDR_W,
    parameter int                DATA_W     = MEM_DATA_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    complex_controller_if.master mem,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    pc
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    cplx_t             r_a, r_b, r_result;
    logic              r_busy, r_done;

    cplx_t             w_alu;
    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rw;

    assign w_op = r_ir[OP_HI:OP_LO];

    complex_alu u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (w_op),
        .result (w_alu)
    );

    // Bus is a pure decode of posedge registers, so it is stable at the negedge.
    always_comb begin
        w_addr = '0;
        w_rw   = 1'b1;
        case (r_state)
            FETCH:  w_addr = r_pc;
            DECODE: if (w_op != OP_HALT) w_addr = {r_ir[BANK_BIT], r_ir[SRC1_HI:SRC1_LO]};
            READ2:  w_addr = {r_ir[BANK_BIT], r_ir[SRC2_HI:SRC2_LO]};
            WRITE: begin
                w_addr = r_ir[DEST_HI:DEST_LO];
                w_rw   = 1'b0;
            end
            default: ;
        endcase
    end

    // Reset overrides the write strobe so a mid-WRITE reset cannot commit.
    assign mem.mem_address    = w_addr;
    assign mem.mem_readwriteN = w_rw | reset;
    assign mem.mem_wdata      = r_result;

    assign busy = r_busy;
    assign done = r_done;
    assign pc   = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= START_ADDR;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    if (start) begin
                        r_pc    <= START_ADDR;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_ir    <= mem.mem_rdata;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= DECODE;
                end
                DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= HALTED;
                    end else begin
                        r_a     <= cplx_t'(mem.mem_rdata);
                        r_state <= READ2;
                    end
                end
                READ2: begin
                    r_b     <= cplx_t'(mem.mem_rdata);
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result <= w_alu;
                    r_state  <= WRITE;
                end
                WRITE:   r_state <= FETCH;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_controller.sv
// Directed bench: behavioural negedge memory plus hand-computed program results.
module tb_complex_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done;
    logic [4:0] pc;

    complex_controller_if bus ();

    complex_controller dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mem   (bus.master),
        .busy  (busy),
        .done  (done),
        .pc    (pc)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:31];
    int writes = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        if (bus.mem_readwriteN === 1'b0) begin
            ram[bus.mem_address] = bus.mem_wdata;
            writes = writes + 1;
        end
        bus.mem_rdata = ram[bus.mem_address];
    end

    task automatic clear_ram;
        for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
    endtask

    task automatic load_std;
        clear_ram();
        ram[0]  = 16'h2036;
        ram[1]  = 16'h6477;
        ram[2]  = 16'hA8B8;
        ram[3]  = 16'h6079;
        ram[4]  = 16'hC000;
        ram[16] = 16'h0304;
        ram[17] = 16'h0709;
        ram[18] = 16'hFA00;
        ram[19] = 16'h040A;
        ram[20] = 16'h0101;
        ram[21] = 16'hF9FB;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int t0, output int n);
        while (done !== 1'b1 && (cyc - t0) < 400) begin
            @(posedge clk);
            #1;
        end
        n = cyc - t0;
    endtask

    task automatic check_std_results(input string tag);
        checks++; if (ram[22] !== 16'h0A0D) begin errors++; $display("FAIL %s_ram22: got %h expected 0a0d", tag, ram[22]); end
        checks++; if (ram[23] !== 16'hF6F6) begin errors++; $display("FAIL %s_ram23: got %h expected f6f6", tag, ram[23]); end
        checks++; if (ram[24] !== 16'hFEF4) begin errors++; $display("FAIL %s_ram24: got %h expected fef4", tag, ram[24]); end
        checks++; if (ram[25] !== 16'hFFFA) begin errors++; $display("FAIL %s_ram25: got %h expected fffa", tag, ram[25]); end
        checks++; if (pc !== 5'd5) begin errors++; $display("FAIL %s_pc: got %0d expected 5", tag, pc); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s_flags: got done=%b busy=%b expected done=1 busy=0", tag, done, busy); end
    endtask

    task automatic test_reset;
        clear_ram();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL rst_pc: got %0d expected 0", pc); end
        checks++; if (bus.mem_address !== 5'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", bus.mem_address); end
        checks++; if (bus.mem_readwriteN !== 1'b1) begin errors++; $display("FAIL rst_rw: got %b expected 1", bus.mem_readwriteN); end
        checks++; if (bus.mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_wdata: got %h expected 0000", bus.mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_standard;
        int t0, n, w0;
        load_std();
        w0 = writes;
        pulse_start(t0);
        checks++; if (busy !== 1'b1 || bus.mem_address !== 5'd0) begin errors++; $display("FAIL std_fetch0: got busy=%b addr=%0d expected busy=1 addr=0", busy, bus.mem_address); end
        wait_done(t0, n);
        checks++; if (n !== 22) begin errors++; $display("FAIL std_cycles: got %0d expected 22", n); end
        checks++; if (writes - w0 !== 4) begin errors++; $display("FAIL std_writes: got %0d expected 4", writes - w0); end
        check_std_results("std");
    endtask

    task automatic test_overflow;
        int t0, n;
        clear_ram();
        ram[0]  = 16'hA034;
        ram[1]  = 16'h2475;
        ram[2]  = 16'hC000;
        ram[16] = 16'h6400;
        ram[17] = 16'h0200;
        ram[18] = 16'h7F00;
        ram[19] = 16'h0100;
        pulse_start(t0);
        wait_done(t0, n);
        checks++; if (ram[20] !== 16'hC800) begin errors++; $display("FAIL ovf_mul: got %h expected c800", ram[20]); end
        checks++; if (ram[21] !== 16'h8000) begin errors++; $display("FAIL ovf_add: got %h expected 8000", ram[21]); end
        checks++; if (n !== 12) begin errors++; $display("FAIL ovf_cycles: got %0d expected 12", n); end
    endtask

    task automatic test_wrap_halt;
        int t0, n, w0;
        clear_ram();
        for (int i = 0; i < 30; i++) ram[i] = 16'h2034;
        ram[30] = 16'h2035;
        ram[31] = 16'hC000;
        ram[16] = 16'h0102;
        ram[17] = 16'h0304;
        w0 = writes;
        pulse_start(t0);
        wait_done(t0, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", done); end
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL wrap_pc: got %0d expected 0", pc); end
        checks++; if (writes - w0 !== 31) begin errors++; $display("FAIL wrap_writes: got %0d expected 31", writes - w0); end
        checks++; if (ram[21] !== 16'h0406) begin errors++; $display("FAIL wrap_ram21: got %h expected 0406", ram[21]); end
        checks++; if (ram[31] !== 16'hC000) begin errors++; $display("FAIL wrap_ram31: got %h expected c000", ram[31]); end
        checks++; if (n !== 157) begin errors++; $display("FAIL wrap_cycles: got %0d expected 157", n); end
    endtask

    task automatic test_reset_in_write;
        int t0;
        load_std();
        ram[22] = 16'hBEEF;
        pulse_start(t0);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus.mem_readwriteN !== 1'b0 || bus.mem_address !== 5'd22) begin errors++; $display("FAIL rw_in_write: got rw=%b addr=%0d expected rw=0 addr=22", bus.mem_readwriteN, bus.mem_address); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_readwriteN !== 1'b1) begin errors++; $display("FAIL rw_forced: got %b expected 1", bus.mem_readwriteN); end
        @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b expected 0", busy); end
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL rw_pc: got %0d expected 0", pc); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ram[22] !== 16'hBEEF) begin errors++; $display("FAIL rw_dest: got %h expected beef", ram[22]); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rw_idle: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_start_while_busy;
        int t0, n, w0;
        load_std();
        w0 = writes;
        pulse_start(t0);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t0, n);
        checks++; if (n !== 22) begin errors++; $display("FAIL busy_cycles: got %0d expected 22", n); end
        checks++; if (writes - w0 !== 4) begin errors++; $display("FAIL busy_writes: got %0d expected 4", writes - w0); end
        check_std_results("busy");
    endtask

    task automatic test_back_to_back;
        int t0, n;
        load_std();
        pulse_start(t0);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_relaunch: got busy=%b done=%b expected 1 0", busy, done); end
        wait_done(t0, n);
        checks++; if (n !== 22) begin errors++; $display("FAIL b2b_cycles: got %0d expected 22", n); end
        check_std_results("b2b");
    endtask

    task automatic test_self_modify;
        int t0, n;
        clear_ram();
        ram[0]  = 16'h2021;
        ram[1]  = 16'h2036;
        ram[16] = 16'hC000;
        ram[17] = 16'h0000;
        pulse_start(t0);
        wait_done(t0, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL smc_cycles: got %0d expected 7", n); end
        checks++; if (ram[1] !== 16'hC000) begin errors++; $display("FAIL smc_ram1: got %h expected c000", ram[1]); end
        checks++; if (pc !== 5'd2) begin errors++; $display("FAIL smc_pc: got %0d expected 2", pc); end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_overflow();
        test_wrap_halt();
        test_reset_in_write();
        test_start_while_busy();
        test_back_to_back();
        test_self_modify();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/complex_controller.md
Name: complex_controller

Overview:
Control and datapath unit that drives the complex processor's shared 32x16 memory as its only initiator. It fetches 16-bit instructions from the memory and reads two complex operands, each packed as {re[7:0], im[7:0]} signed. It executes add, subtract or multiply and writes the result back through the same single-port read/write interface. The memory responder samples on negedge clk; this block drives all memory signals from posedge clk.

Parameters:
START_ADDR, 5'd0, PC value loaded on start.
ADDR_W, 5, memory address width.
DATA_W, 16, memory word width (8-bit real part, 8-bit imaginary part).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins execution at START_ADDR when IDLE or HALTED.
mem_address  output  5  memory address.
mem_readwriteN  output  1  1 = read, 0 = write.
mem_wdata  output  16  write data, connected to memory data_in.
mem_rdata  input  16  read data, from memory data_out; valid one posedge after the address is driven.
busy  output  1  high in every state except IDLE and HALTED.
done  output  1  high while HALTED.
pc  output  5  current program counter.

Behaviour:
- Reset values: state=IDLE, pc=START_ADDR, mem_address=0, mem_readwriteN=1, mem_wdata=0, busy=0, done=0. IR, A, B and result registers are cleared to 0.
- mem_readwriteN is forced to 1 combinationally while reset=1. This prevents a spurious negedge write when reset is asserted mid-WRITE.
- Instruction format:
  - [15:14] opcode: 00 add, 01 sub, 10 mul, 11 halt.
  - [13] bank bit.
  - [12:9] src1, [8:5] src2.
  - [4:0] dest.
- Operand addresses are {bank, src1} and {bank, src2}. dest is a direct address.
- Read timing: the address is driven at posedge N, the memory updates at the negedge, and mem_rdata is latched at posedge N+1. Read latency is one cycle.
- FSM:
  - IDLE: memory idle (read, addr 0). On start: pc<=START_ADDR, go to FETCH.
  - FETCH: addr=pc, rw=1. At end of cycle: IR<=mem_rdata, pc<=pc+1 (5-bit wrap, 31->0), go to DECODE.
  - DECODE: if IR opcode=11, go to HALTED with no memory access. Otherwise addr={bank, src1}; at end A<=mem_rdata, go to READ2.
  - READ2: addr={bank, src2}; at end B<=mem_rdata, go to EXEC.
  - EXEC: result<=alu(A, B, op), memory idle as read, go to WRITE.
  - WRITE: addr=dest, rw=0, mem_wdata=result, go to FETCH.
  - HALTED: done=1, memory idle as read. start re-launches from START_ADDR.
- Each non-halt instruction takes 5 cycles. A halt instruction takes 2 cycles (FETCH, DECODE).
- start is ignored while busy.
- Arithmetic: real and imaginary parts are signed 8-bit and every result part is truncated to 8 bits (two's-complement wrap, no saturation).
  - add: (ar+br, ai+bi).
  - sub: (ar-br, ai-bi).
  - mul: (ar*br - ai*bi, ar*bi + ai*br), with 16-bit internal products and sum before truncation.
- Self-modifying code is legal: a WRITE to an address later fetched returns the new value.
- src1=src2 is legal.
- dest may overwrite an operand or an instruction.

Decomposition:
- Package complex_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_HALT.
  - instruction field bit positions.
  - state enum IDLE/FETCH/DECODE/READ2/EXEC/WRITE/HALTED.
  - complex word typedef {re, im}.
- Sub-module complex_alu: combinational; takes A, B and op, returns the 16-bit truncated result.

Test Plan:
- Load the standard program (words 0-4 plus data at 16-21), pulse start -> ram[22]=0x0A0D, ram[23]=0xF6F6, ram[24]=0xFEF4, ram[25]=0xFFFA. done rises 22 cycles after start, with pc=5.
- Overflow: mul (100+0i)*(2+0i) -> written word 0xC800. add (127+0i)+(1+0i) -> 0x8000.
- Halt at word 31, preceded by add at 30 -> pc wraps to 0 after the halt fetch. done=1, no write cycle issued for the halt.
- Assert reset for 1 cycle during WRITE -> mem_readwriteN=1 in that cycle, dest unchanged. Next cycle: IDLE, busy=0, pc=0.
- Pulse start while busy (in READ2) -> ignored; program results and total cycle count identical to the undisturbed run.
- Self-modify: instruction 0 writes 0xC000 (halt) to address 1 -> second fetch halts. done asserted 7 cycles after start.
